// File: rtl/sram_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-lite arbiter in front of the SRAM model.
// One transaction in flight; requests are registered before reaching the slave, responses go to the owner only.
module sram_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              areset,
  // IFU read
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // LSU read
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // LSU write
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  output logic [1:0]        m1_bresp,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  // SRAM side
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  output logic              s_wvalid,
  input  logic              s_wready,
  input  logic [1:0]        s_bresp,
  input  logic              s_bvalid,
  output logic              s_bready
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and a master's readies are only ever raised in IDLE.
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic m0_req, m1_wr_req, m1_req, grant_m1;
  logic aw_fin, w_fin, rready_sel;

  assign m0_req     = m0_arvalid;
  assign m1_wr_req  = m1_awvalid & m1_wvalid;
  assign m1_req     = m1_wr_req | m1_arvalid;
  // M1 wins if alone, or if M0 was the previous grant.
  assign grant_m1   = m1_req & (~m0_req | (last_grant_q == M0));

  assign aw_fin     = aw_done_q | s_awready;
  assign w_fin      = w_done_q | s_wready;
  assign rready_sel = (owner_q == M1) ? m1_rready : m0_rready;

  assign s_araddr = addr_q;
  assign s_awaddr = addr_q;
  assign s_wdata  = wdata_q;
  assign s_wstrb  = wstrb_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      owner_q      <= M0;
      last_grant_q <= M1;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    m0_arready   = 1'b0;
    m1_arready   = 1'b0;
    m1_awready   = 1'b0;
    m1_wready    = 1'b0;
    m0_rdata     = '0;
    m0_rresp     = '0;
    m0_rvalid    = 1'b0;
    m1_rdata     = '0;
    m1_rresp     = '0;
    m1_rvalid    = 1'b0;
    m1_bresp     = '0;
    m1_bvalid    = 1'b0;
    s_arvalid    = 1'b0;
    s_rready     = 1'b0;
    s_awvalid    = 1'b0;
    s_wvalid     = 1'b0;
    s_bready     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Readies are suppressed while reset is held so nothing is granted during reset.
        if (!areset) begin
          if (grant_m1 && m1_wr_req) begin
            m1_awready   = 1'b1;
            m1_wready    = 1'b1;
            addr_d       = m1_awaddr;
            wdata_d      = m1_wdata;
            wstrb_d      = m1_wstrb;
            owner_d      = M1;
            last_grant_d = M1;
            state_d      = WR_REQ;
          end else if (grant_m1) begin
            m1_arready   = 1'b1;
            addr_d       = m1_araddr;
            owner_d      = M1;
            last_grant_d = M1;
            state_d      = RD_ADDR;
          end else if (m0_req) begin
            m0_arready   = 1'b1;
            addr_d       = m0_araddr;
            owner_d      = M0;
            last_grant_d = M0;
            state_d      = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        s_arvalid = 1'b1;
        if (s_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        s_rready = rready_sel;
        if (owner_q == M1) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
        end
        if (s_rvalid && rready_sel) state_d = IDLE;
      end
      WR_REQ: begin
        s_awvalid = ~aw_done_q;
        s_wvalid  = ~w_done_q;
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        m1_bvalid = s_bvalid;
        m1_bresp  = s_bresp;
        s_bready  = m1_bready;
        if (s_bvalid && m1_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed bench for sram_axi_arbiter: SRAM responder, master driver tasks, per-scenario checks.
`timescale 1ns/1ps
module tb_sram_axi_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 8;

  logic          aclk = 1'b0;
  logic          areset;
  logic [AW-1:0] m0_araddr, m1_araddr, m1_awaddr, s_araddr, s_awaddr;
  logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic          m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [DW-1:0] m0_rdata, m1_rdata, m1_wdata, s_rdata, s_wdata;
  logic [1:0]    m0_rresp, m1_rresp, m1_bresp, s_rresp, s_bresp;
  logic [SW-1:0] m1_wstrb, s_wstrb;
  logic          s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic          s_wvalid, s_wready, s_bvalid, s_bready;

  int errors = 0;
  int checks = 0;

  // Slave model state and statistics
  logic          slave_en = 1'b1;
  int            aw_delay = 0;
  int            aw_wait = 0;
  logic          aw_got = 1'b0, w_got = 1'b0;
  int            ar_cnt, aw_cnt, w_cnt, s_awv_cyc, s_wv_cyc;
  logic [AW-1:0] last_awaddr;
  logic [DW-1:0] last_wdata;
  logic [SW-1:0] last_wstrb;

  // Monitor logs
  int            grant_q[$];
  logic [DW-1:0] m0_rx_q[$];
  logic [DW-1:0] m1_rx_q[$];
  logic [DW-1:0] exp_q[$];
  logic [1:0]    last_m0_rresp;
  int            mb_cnt, m1_rv_cyc, leak_cnt;

  sram_axi_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(aclk), .areset(areset),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  // Clock / reset
  always #5 aclk = ~aclk;

  function automatic logic [DW-1:0] sram_data(input logic [AW-1:0] a);
    if (a == 32'h8000_0000) return 64'h0000_0013_0000_0297;
    return {a, a ^ 32'h5A5A_5A5A};
  endfunction

  task automatic clear_logs();
    grant_q.delete(); m0_rx_q.delete(); m1_rx_q.delete(); exp_q.delete();
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; s_awv_cyc = 0; s_wv_cyc = 0;
    mb_cnt = 0; m1_rv_cyc = 0; leak_cnt = 0; last_m0_rresp = 2'bxx;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m1_awvalid = 1'b0; m1_wvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    clear_logs();
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // SRAM responder: zero-wait AR/W, configurable AW stall, R/B one cycle after request.
  initial begin : slave_model
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_stall;
    logic [AW-1:0] ar_a;
    s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0; s_bresp = '0;
    forever begin
      @(negedge aclk);
      ar_hs    = s_arvalid & s_arready;
      ar_a     = s_araddr;
      r_hs     = s_rvalid & s_rready;
      aw_hs    = s_awvalid & s_awready;
      w_hs     = s_wvalid & s_wready;
      b_hs     = s_bvalid & s_bready;
      aw_stall = s_awvalid & ~s_awready;
      if (s_awvalid) s_awv_cyc++;
      if (s_wvalid) s_wv_cyc++;
      if (aw_hs) begin aw_cnt++; last_awaddr = s_awaddr; end
      if (w_hs) begin w_cnt++; last_wdata = s_wdata; last_wstrb = s_wstrb; end
      @(posedge aclk);
      #1;
      if (!slave_en) begin
        aw_wait = 0; aw_got = 1'b0; w_got = 1'b0;
      end else begin
        if (r_hs) s_rvalid = 1'b0;
        if (ar_hs) begin ar_cnt++; s_rvalid = 1'b1; s_rdata = sram_data(ar_a); s_rresp = 2'b00; end
        if (b_hs) s_bvalid = 1'b0;
        if (aw_hs) begin
          aw_got = 1'b1; aw_wait = 0; s_awready = (aw_delay == 0);
        end else if (aw_stall) begin
          aw_wait++;
          if (aw_wait >= aw_delay) s_awready = 1'b1;
        end
        if (w_hs) w_got = 1'b1;
        if (aw_got && w_got) begin s_bvalid = 1'b1; s_bresp = 2'b00; aw_got = 1'b0; w_got = 1'b0; end
      end
    end
  end

  // Master-side monitor
  initial begin : monitor
    forever begin
      @(negedge aclk);
      if (m0_arvalid && m0_arready) grant_q.push_back(0);
      if (m1_arvalid && m1_arready) grant_q.push_back(1);
      if (m1_awvalid && m1_awready && m1_wvalid && m1_wready) grant_q.push_back(2);
      if (m0_rvalid && m0_rready) begin m0_rx_q.push_back(m0_rdata); last_m0_rresp = m0_rresp; end
      if (m1_rvalid && m1_rready) m1_rx_q.push_back(m1_rdata);
      if (m1_bvalid && m1_bready) mb_cnt++;
      if (m1_rvalid) m1_rv_cyc++;
      if ((m0_rvalid && (m1_rvalid || m1_rdata != '0)) || (m1_rvalid && (m0_rvalid || m0_rdata != '0)))
        leak_cnt++;
    end
  end

  // Driver tasks (called at posedge+1)
  task automatic m_read(input int m, input logic [AW-1:0] a);
    int   t = 0;
    logic ok = 1'b0;
    if (m == 0) begin m0_araddr = a; m0_arvalid = 1'b1; end
    else begin m1_araddr = a; m1_arvalid = 1'b1; end
    while (!ok && t <= 100) begin
      @(negedge aclk);
      ok = (m == 0) ? m0_arready : m1_arready;
      t++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ar_timeout_m%0d: arready=0 after %0d cycles, required 1", m, t);
    end
    @(posedge aclk);
    #1;
    if (m == 0) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
  endtask

  task automatic m_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    int   t = 0;
    logic ok = 1'b0;
    m1_awaddr = a; m1_wdata = d; m1_wstrb = s;
    m1_awvalid = 1'b1; m1_wvalid = 1'b1;
    while (!ok && t <= 100) begin
      @(negedge aclk);
      ok = m1_awready & m1_wready;
      t++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL aw_w_timeout: awready&wready=0 after %0d cycles, required 1", t);
    end
    @(posedge aclk);
    #1;
    m1_awvalid = 1'b0; m1_wvalid = 1'b0;
  endtask

  task automatic set_aw_delay(input int d);
    aw_delay = d;
    s_awready = (d == 0);
  endtask

  // Scenarios
  task automatic test_reset();
    areset = 1'b1;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    #1;
    checks++;
    if ({m0_arready, m1_arready, m1_awready, m1_wready} !== 4'b0) begin
      errors++; $display("FAIL rst_master_ready: got %b, required 0000", {m0_arready, m1_arready, m1_awready, m1_wready});
    end
    checks++;
    if ({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, m0_rvalid, m1_rvalid, m1_bvalid} !== 8'b0) begin
      errors++; $display("FAIL rst_valids: got %b, required 00000000",
        {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, m0_rvalid, m1_rvalid, m1_bvalid});
    end
    checks++;
    if ({s_araddr, s_awaddr, s_wdata, s_wstrb, m0_rdata, m1_rdata} !== '0) begin
      errors++; $display("FAIL rst_data: got araddr=%h wdata=%h m0_rdata=%h, required all 0", s_araddr, s_wdata, m0_rdata);
    end
    @(posedge aclk);
    #1 areset = 1'b0;
    #1;
    checks++;
    if ({m0_arready, m1_arready} !== 2'b10) begin
      errors++; $display("FAIL first_tie: got m0/m1 arready=%b, required 10", {m0_arready, m1_arready});
    end
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    slave_en = 1'b0;
    s_rvalid = 1'b1; s_bvalid = 1'b1;
    #1;
    checks++;
    if ({s_rready, s_bready, m0_rvalid, m1_rvalid, m1_bvalid} !== 5'b0) begin
      errors++; $display("FAIL idle_stray_resp: got %b, required 00000", {s_rready, s_bready, m0_rvalid, m1_rvalid, m1_bvalid});
    end
    s_rvalid = 1'b0; s_bvalid = 1'b0;
    settle(1);
    slave_en = 1'b1;
    clear_logs();
  endtask

  task automatic test_single_read();
    do_reset();
    m_read(0, 32'h8000_0000);
    settle(8);
    checks++;
    if (m0_rx_q.size() != 1 || m0_rx_q[0] !== 64'h0000_0013_0000_0297) begin
      errors++; $display("FAIL m0_rdata: got %0d beats first=%h, required 1 beat 0000001300000297",
        m0_rx_q.size(), m0_rx_q.size() > 0 ? m0_rx_q[0] : '0);
    end
    checks++;
    if (last_m0_rresp !== 2'b00) begin
      errors++; $display("FAIL m0_rresp: got %b, required 00", last_m0_rresp);
    end
    checks++;
    if (m1_rv_cyc != 0 || ar_cnt != 1) begin
      errors++; $display("FAIL m1_quiet: got m1_rvalid cycles=%0d slave ARs=%0d, required 0 and 1", m1_rv_cyc, ar_cnt);
    end
  endtask

  task automatic test_round_robin();
    int exp_g[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    logic ok;
    do_reset();
    fork
      begin for (int i = 0; i < 4; i++) m_read(0, 32'h8000_0100 + i * 8); end
      begin for (int i = 0; i < 4; i++) m_read(1, 32'h8000_2000 + i * 8); end
    join
    settle(10);
    ok = (grant_q.size() == 8);
    for (int i = 0; i < 8 && ok; i++) if (grant_q[i] != exp_g[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rr_order: got %p, required 0,1,0,1,0,1,0,1", grant_q);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(sram_data(32'h8000_0100 + i * 8));
    checks++;
    if (m0_rx_q != exp_q) begin
      errors++; $display("FAIL rr_m0_data: got %p, required %p", m0_rx_q, exp_q);
    end
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(sram_data(32'h8000_2000 + i * 8));
    checks++;
    if (m1_rx_q != exp_q) begin
      errors++; $display("FAIL rr_m1_data: got %p, required %p", m1_rx_q, exp_q);
    end
    checks++;
    if (leak_cnt != 0) begin
      errors++; $display("FAIL rr_isolation: got %0d leak cycles, required 0", leak_cnt);
    end
  endtask

  task automatic test_write();
    do_reset();
    m_write(32'h8000_1000, 64'h1122_3344_5566_7788, 8'h0F);
    settle(8);
    checks++;
    if (aw_cnt != 1 || w_cnt != 1 || mb_cnt != 1) begin
      errors++; $display("FAIL wr_counts: got aw=%0d w=%0d b=%0d, required 1 1 1", aw_cnt, w_cnt, mb_cnt);
    end
    checks++;
    if (last_awaddr !== 32'h8000_1000 || last_wdata !== 64'h1122_3344_5566_7788 || last_wstrb !== 8'h0F) begin
      errors++; $display("FAIL wr_payload: got addr=%h data=%h strb=%h, required 80001000 1122334455667788 0f",
        last_awaddr, last_wdata, last_wstrb);
    end
  endtask

  task automatic test_aw_stall();
    do_reset();
    set_aw_delay(2);
    m_write(32'h8000_1008, 64'hCAFE_F00D_0000_0001, 8'hFF);
    settle(10);
    checks++;
    if (s_awv_cyc != 3 || s_wv_cyc != 1) begin
      errors++; $display("FAIL aw_stall_valids: got awvalid cycles=%0d wvalid cycles=%0d, required 3 and 1", s_awv_cyc, s_wv_cyc);
    end
    checks++;
    if (aw_cnt != 1 || w_cnt != 1 || mb_cnt != 1) begin
      errors++; $display("FAIL aw_stall_counts: got aw=%0d w=%0d b=%0d, required 1 1 1", aw_cnt, w_cnt, mb_cnt);
    end
    set_aw_delay(0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    fork
      m_write(32'h8000_3000, 64'h0123_4567_89AB_CDEF, 8'hF0);
      m_read(1, 32'h8000_3008);
      begin @(posedge aclk); #1; m_read(0, 32'h8000_0200); end
    join
    settle(10);
    checks++;
    if (grant_q.size() != 3 || grant_q[0] != 2 || grant_q[1] != 0 || grant_q[2] != 1) begin
      errors++; $display("FAIL b2b_order: got %p, required write(2),m0(0),m1(1)", grant_q);
    end
    checks++;
    if (m0_rx_q.size() != 1 || m0_rx_q[0] !== sram_data(32'h8000_0200) ||
        m1_rx_q.size() != 1 || m1_rx_q[0] !== sram_data(32'h8000_3008)) begin
      errors++; $display("FAIL b2b_data: got m0=%p m1=%p, required %h and %h",
        m0_rx_q, m1_rx_q, sram_data(32'h8000_0200), sram_data(32'h8000_3008));
    end
    checks++;
    if (mb_cnt != 1 || last_awaddr !== 32'h8000_3000) begin
      errors++; $display("FAIL b2b_write: got b=%0d awaddr=%h, required 1 and 80003000", mb_cnt, last_awaddr);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    slave_en = 1'b0;
    s_arready = 1'b1; s_rvalid = 1'b0;
    m_read(0, 32'h8000_0010);
    settle(1);
    checks++;
    if (s_rready !== 1'b1) begin
      errors++; $display("FAIL mid_rd_data: got s_rready=%b, required 1", s_rready);
    end
    areset = 1'b1;
    #1;
    checks++;
    if ({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, m0_arready, m1_arready,
         m1_awready, m1_wready, m0_rvalid, m1_rvalid, m1_bvalid} !== 12'b0 || s_araddr !== '0) begin
      errors++; $display("FAIL mid_rst_outputs: got %b araddr=%h, required all 0",
        {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, m0_arready, m1_arready,
         m1_awready, m1_wready, m0_rvalid, m1_rvalid, m1_bvalid}, s_araddr);
    end
    @(posedge aclk);
    #1 areset = 1'b0;
    s_rvalid = 1'b1; s_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    checks++;
    if ({s_rready, m0_rvalid} !== 2'b00 || m0_rdata !== '0) begin
      errors++; $display("FAIL late_rvalid: got s_rready=%b m0_rvalid=%b m0_rdata=%h, required 0 0 0", s_rready, m0_rvalid, m0_rdata);
    end
    settle(2);
    s_rvalid = 1'b0; s_rdata = '0;
    checks++;
    if (m0_rx_q.size() != 0) begin
      errors++; $display("FAIL abandoned_resp: got %0d m0 beats, required 0", m0_rx_q.size());
    end
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0;
    slave_en = 1'b1;
    settle(1);
    m_read(0, 32'h8000_0040);
    settle(8);
    checks++;
    if (m0_rx_q.size() != 1 || m0_rx_q[0] !== sram_data(32'h8000_0040)) begin
      errors++; $display("FAIL post_rst_read: got %p, required %h", m0_rx_q, sram_data(32'h8000_0040));
    end
  endtask

  initial begin
    areset = 1'b1;
    m0_araddr = '0; m0_arvalid = 1'b0; m0_rready = 1'b1;
    m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
    m1_awaddr = '0; m1_awvalid = 1'b0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 1'b0; m1_bready = 1'b1;
    clear_logs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_aw_stall();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
